// File: rtl/cnn_frame_feeder.sv
// Frame feeder for the CNN chip: buffers one host image, resets the
// chip, streams the pixels and returns the chip decision to the host.
module cnn_frame_feeder #(
  parameter int IMG_PIX = 784,
  parameter int PIX_W   = 8,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 8192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_last,
  output logic             cnn_rst_n,
  output logic [PIX_W-1:0] cnn_data,
  input  logic [3:0]       cnn_decision,
  input  logic             cnn_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_decision,
  output logic             res_error,
  output logic             frame_err,
  output logic             busy
);

  localparam int AW = $clog2(IMG_PIX);
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(RST_CYC + 1);

  typedef enum logic [2:0] {
    S_LOAD, S_RSTC, S_STREAM, S_WAIT, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            s_ready_q, s_ready_d;
  logic            cnn_rst_n_q, cnn_rst_n_d;
  logic            res_valid_q, res_valid_d;
  logic [3:0]      res_dec_q, res_dec_d;
  logic            res_err_q, res_err_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic [PIX_W-1:0] rd_data_q;
  logic [PIX_W-1:0] mem [IMG_PIX];

  logic accept;
  logic last_pix;

  assign accept   = s_valid & s_ready_q & (state_q == S_LOAD);
  assign last_pix = (wr_cnt_q == AW'(IMG_PIX - 1));

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      s_ready_q   <= 1'b0;
      cnn_rst_n_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_dec_q   <= '0;
      res_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      s_ready_q   <= s_ready_d;
      cnn_rst_n_q <= cnn_rst_n_d;
      res_valid_q <= res_valid_d;
      res_dec_q   <= res_dec_d;
      res_err_q   <= res_err_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Frame buffer with registered read; address is prefetched one cycle
  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt_q] <= s_data;
    rd_data_q <= mem[rd_cnt_d];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:   if (accept && last_pix) state_d = S_RSTC;
      S_RSTC:   if (rst_cnt_q == CW'(RST_CYC - 1)) state_d = S_STREAM;
      S_STREAM: if (rd_cnt_q == AW'(IMG_PIX - 1)) state_d = S_WAIT;
      S_WAIT: begin
        if (cnn_valid || to_cnt_q == TW'(TIMEOUT - 1)) state_d = S_DONE;
      end
      S_DONE:   if (res_ready) state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  // Counters; each clears when its state is left so none ever wraps
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (accept) begin
      wr_cnt_d = (last_pix || s_last) ? '0 : wr_cnt_q + 1'b1;
    end
    rst_cnt_d = '0;
    if (state_q == S_RSTC && state_d == S_RSTC) rst_cnt_d = rst_cnt_q + 1'b1;
    rd_cnt_d = '0;
    if (state_q == S_STREAM && state_d == S_STREAM) rd_cnt_d = rd_cnt_q + 1'b1;
    to_cnt_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) to_cnt_d = to_cnt_q + 1'b1;
  end

  // Registered outputs, computed from the upcoming state
  always_comb begin
    s_ready_d   = (state_d == S_LOAD);
    busy_d      = (state_d != S_LOAD);
    res_valid_d = (state_d == S_DONE);
    frame_err_d = accept & (s_last ^ last_pix);
    cnn_rst_n_d = cnn_rst_n_q;
    unique case (1'b1)
      state_d == S_RSTC:   cnn_rst_n_d = 1'b0;
      state_d == S_STREAM: cnn_rst_n_d = 1'b1;
      state_d == S_WAIT:   cnn_rst_n_d = 1'b1;
      state_d == S_DONE:   cnn_rst_n_d = 1'b1;
      default:             cnn_rst_n_d = cnn_rst_n_q;
    endcase
    res_dec_d = res_dec_q;
    res_err_d = res_err_q;
    if (state_q == S_WAIT && state_d == S_DONE) begin
      res_dec_d = cnn_valid ? cnn_decision : 4'hF;
      res_err_d = ~cnn_valid;
    end
  end

  assign s_ready      = s_ready_q;
  assign cnn_rst_n    = cnn_rst_n_q;
  assign cnn_data     = (state_q == S_STREAM) ? rd_data_q : '0;
  assign res_valid    = res_valid_q;
  assign res_decision = res_dec_q;
  assign res_error    = res_err_q;
  assign frame_err    = frame_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Directed bench for cnn_frame_feeder: normal frames, framing errors,
// timeout and reset in the middle of streaming.
module tb_cnn_frame_feeder;

  localparam int N = 784;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       cnn_rst_n;
  logic [7:0] cnn_data;
  logic [3:0] cnn_decision;
  logic       cnn_valid;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_decision;
  logic       res_error;
  logic       frame_err;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;

  cnn_frame_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .cnn_rst_n    (cnn_rst_n),
    .cnn_data     (cnn_data),
    .cnn_decision (cnn_decision),
    .cnn_valid    (cnn_valid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_decision (res_decision),
    .res_error    (res_error),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int n, input int last_at, input int base);
    int stall;
    stall = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b1) stall++;
      s_valid = 1'b1;
      s_data  = 8'((i + base) % 256);
      s_last  = (i == last_at);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("send_ready", 32'(stall), 0);
  endtask

  task automatic stream_chk(input int base, input string tag);
    int rc, bad;
    rc = 0;
    while (cnn_rst_n === 1'b0 && rc < 20) begin
      rc++;
      @(negedge clk);
    end
    chk({tag, "_rstc_len"}, 32'(rc), 4);
    bad = 0;
    for (int k = 0; k < N; k++) begin
      if (cnn_data !== 8'((k + base) % 256) || cnn_rst_n !== 1'b1 ||
          busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk({tag, "_stream"}, 32'(bad), 0);
    chk({tag, "_wait_data"}, 32'(cnn_data), 0);
    chk({tag, "_wait_rv"}, 32'(res_valid), 0);
  endtask

  task automatic result(input logic [3:0] dec, input string tag);
    int bad;
    cnn_valid    = 1'b1;
    cnn_decision = dec;
    @(negedge clk);
    cnn_valid    = 1'b0;
    cnn_decision = 4'h0;
    chk({tag, "_res_valid"}, 32'(res_valid), 1);
    chk({tag, "_res_dec"}, 32'(res_decision), 32'(dec));
    chk({tag, "_res_err"}, 32'(res_error), 0);
  endtask

  task automatic ack(input logic [3:0] dec, input logic err,
                     input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_decision !== dec ||
          res_error !== err || s_ready !== 1'b0) bad++;
    end
    chk({tag, "_hold"}, 32'(bad), 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_s_ready"}, 32'(s_ready), 1);
    chk({tag, "_rv_drop"}, 32'(res_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_cnn_rst_n"}, 32'(cnn_rst_n), 0);
    chk({tag, "_cnn_data"}, 32'(cnn_data), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_dec"}, 32'(res_decision), 0);
    chk({tag, "_res_err"}, 32'(res_error), 0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int wc, fe0, rc;
    rst          = 1'b1;
    s_valid      = 1'b0;
    s_data       = 8'h0;
    s_last       = 1'b0;
    cnn_decision = 4'h0;
    cnn_valid    = 1'b0;
    res_ready    = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(s_ready), 1);

    // Normal frame, decision 7
    send(N, N - 1, 0);
    stream_chk(0, "f1");
    chk("f1_no_ferr", 32'(fe_cnt), 0);
    result(4'd7, "f1");
    ack(4'd7, 1'b0, "f1");

    // Early s_last on byte 100 discards the frame
    send(100, 99, 200);
    @(negedge clk);
    chk("early_ferr", 32'(fe_cnt), 1);
    chk("early_ready", 32'(s_ready), 1);
    chk("early_busy", 32'(busy), 0);

    // Good frame after the discard, left to time out
    send(N, N - 1, 37);
    stream_chk(37, "f2");
    chk("f2_ferr", 32'(fe_cnt), 1);
    wc = 0;
    while (res_valid !== 1'b1 && wc < 10000) begin
      wc++;
      @(negedge clk);
    end
    chk("to_len", 32'(wc), 8192);
    chk("to_dec", 32'(res_decision), 32'hF);
    chk("to_err", 32'(res_error), 1);
    ack(4'hF, 1'b1, "to");

    // Missing s_last: flagged but still streamed; cnn_valid outside WAIT ignored
    cnn_valid    = 1'b1;
    cnn_decision = 4'd9;
    fe0 = fe_cnt;
    send(N, -1, 5);
    cnn_valid    = 1'b0;
    cnn_decision = 4'd0;
    stream_chk(5, "f3");
    chk("f3_ferr", 32'(fe_cnt - fe0), 1);
    result(4'd3, "f3");
    ack(4'd3, 1'b0, "f3");

    // Reset at stream pixel 300
    send(N, N - 1, 11);
    rc = 0;
    while (cnn_rst_n === 1'b0 && rc < 20) begin
      rc++;
      @(negedge clk);
    end
    repeat (300) @(negedge clk);
    chk("mid_pix300", 32'(cnn_data), 32'((300 + 11) % 256));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("mid");
    @(negedge clk);
    chk("mid_ready", 32'(s_ready), 1);
    send(N, N - 1, 99);
    stream_chk(99, "f4");
    result(4'd12, "f4");
    ack(4'd12, 1'b0, "f4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
